// File: rtl/multicycle_core.sv
// multicycle_core: multicycle soft core (FETCH/DECODE/EXEC/WB) against a synchronous
// instruction ROM, with a ready/valid switch input, OUT-driven display register and halt.
module multicycle_core #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic [DATA_W-1:0] SW,
  input  logic              sw_valid,
  output logic              sw_ready,
  output logic [DATA_W-1:0] HEX,
  output logic              hex_valid,
  output logic              halted
);

  localparam int RA_W = $clog2(NREGS);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_imem_addr;
  logic [PC_W-1:0]   r_npc;
  logic              r_j;
  logic              r_b;
  logic              r_we;
  logic [1:0]        r_ws;
  logic [3:0]        r_op;
  logic [4:0]        r_a3;
  logic [7:0]        r_imm;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_sw_data;
  logic              r_sw_ready;
  logic [DATA_W-1:0] r_hex;
  logic              r_hex_valid;
  logic              r_halted;
  logic [DATA_W-1:0] r_regs [NREGS];

  logic [4:0]        w_ra1;
  logic [4:0]        w_ra2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_se;
  logic [PC_W-1:0]   w_off;
  logic [SH_W-1:0]   w_sh;
  logic [DATA_W-1:0] w_res;
  logic              w_flag;
  logic [PC_W-1:0]   w_npc;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_en;
  logic              w_is_halt;

  // Operands are read straight from the ROM word in DECODE, in parallel with the IR latch.
  assign w_ra1 = imem_rdata[22:18];
  assign w_ra2 = imem_rdata[17:13];
  assign w_rd1 = (w_ra1 != '0 && int'(w_ra1) < NREGS) ? r_regs[w_ra1[RA_W-1:0]] : '0;
  assign w_rd2 = (w_ra2 != '0 && int'(w_ra2) < NREGS) ? r_regs[w_ra2[RA_W-1:0]] : '0;

  assign w_se      = DATA_W'($signed(r_imm));
  assign w_off     = PC_W'($signed(r_imm));
  assign w_sh      = r_opb[SH_W-1:0];
  assign w_is_halt = r_j && (r_imm == '0);

  always_comb begin
    w_res  = '0;
    w_flag = 1'b0;
    case (r_op)
      4'h0: w_res = r_opa + r_opb;
      4'h1: w_res = r_opa - r_opb;
      4'h2: w_res = r_opa & r_opb;
      4'h3: w_res = r_opa | r_opb;
      4'h4: w_res = r_opa ^ r_opb;
      4'h5: w_res = r_opa << w_sh;
      4'h6: w_res = r_opa >> w_sh;
      4'h7: w_res = $signed(r_opa) >>> w_sh;
      4'h8: w_flag = $signed(r_opa) < $signed(r_opb);
      4'h9: w_flag = r_opa < r_opb;
      4'hA: w_flag = r_opa == r_opb;
      4'hB: w_flag = r_opa != r_opb;
      4'hC: w_flag = $signed(r_opa) >= $signed(r_opb);
      4'hD: w_flag = r_opa >= r_opb;
      default: begin
        w_res  = '0;
        w_flag = 1'b0;
      end
    endcase
    if (r_op >= 4'h8 && r_op <= 4'hD) w_res = DATA_W'(w_flag);
  end

  assign w_npc = (r_j || (r_b && w_flag)) ? r_pc + w_off : r_pc + PC_W'(1);

  always_comb begin
    case (r_ws)
      2'b00:   w_wdata = w_se;
      2'b01:   w_wdata = r_sw_data;
      default: w_wdata = r_alu;
    endcase
  end

  assign w_wr_en = (r_state == S_WB) && r_we && (r_ws != 2'b11) &&
                   (r_a3 != '0) && (int'(r_a3) < NREGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[RA_W'(i)] <= '0;
    end else if (w_wr_en) begin
      r_regs[r_a3[RA_W-1:0]] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_imem_addr <= '0;
      r_npc       <= '0;
      r_j         <= 1'b0;
      r_b         <= 1'b0;
      r_we        <= 1'b0;
      r_ws        <= '0;
      r_op        <= '0;
      r_a3        <= '0;
      r_imm       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_alu       <= '0;
      r_sw_data   <= '0;
      r_sw_ready  <= 1'b0;
      r_hex       <= '0;
      r_hex_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_hex_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_imem_addr <= r_pc;
          r_state     <= S_DECODE;
        end
        S_DECODE: begin
          {r_j, r_b, r_we, r_ws, r_op} <= imem_rdata[31:23];
          r_a3    <= imem_rdata[12:8];
          r_imm   <= imem_rdata[7:0];
          r_opa   <= w_rd1;
          r_opb   <= w_rd2;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu <= w_res;
          r_npc <= w_npc;
          // sw_ready is raised together with the state change so it stays a clean flop output.
          if (r_we && r_ws == 2'b01) begin
            r_sw_ready <= 1'b1;
            r_state    <= S_WAIT;
          end else begin
            r_state <= S_WB;
          end
        end
        S_WAIT: begin
          if (sw_valid && r_sw_ready) begin
            r_sw_data  <= SW;
            r_sw_ready <= 1'b0;
            r_state    <= S_WB;
          end
        end
        S_WB: begin
          if (r_ws == 2'b11) begin
            r_hex       <= r_opa;
            r_hex_valid <= 1'b1;
          end
          r_pc <= r_npc;
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem_addr = r_imem_addr;
  assign sw_ready  = r_sw_ready;
  assign HEX       = r_hex;
  assign hex_valid = r_hex_valid;
  assign halted    = r_halted;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: instruction-level reference model checked every cycle,
// directed programs with literal expectations, plus a 16-bit/4-bit-PC/8-register build.
module tb_multicycle_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sw_valid, sw_ready, hex_valid, halted;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata, SW, HEX;
  logic [31:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  multicycle_core dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .SW(SW), .sw_valid(sw_valid), .sw_ready(sw_ready),
    .HEX(HEX), .hex_valid(hex_valid), .halted(halted)
  );

  logic        reset16, sw_valid16, sw_ready16, hex_valid16, halted16;
  logic [3:0]  imem_addr16;
  logic [31:0] imem_rdata16;
  logic [15:0] SW16, HEX16;
  logic [31:0] mem16 [16];
  assign imem_rdata16 = mem16[imem_addr16];

  multicycle_core #(.DATA_W(16), .PC_W(4), .NREGS(8)) dut16 (
    .clk(clk), .reset(reset16), .imem_addr(imem_addr16), .imem_rdata(imem_rdata16),
    .SW(SW16), .sw_valid(sw_valid16), .sw_ready(sw_ready16),
    .HEX(HEX16), .hex_valid(hex_valid16), .halted(halted16)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic j, input logic b, input logic we,
      input logic [1:0] ws, input logic [3:0] op, input logic [4:0] a1,
      input logic [4:0] a2, input logic [4:0] a3, input logic [7:0] imm);
    return {j, b, we, ws, op, a1, a2, a3, imm};
  endfunction
  function automatic logic [31:0] LI(input logic [4:0] rd, input logic [7:0] imm);
    return enc(1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 5'd0, 5'd0, rd, imm);
  endfunction
  function automatic logic [31:0] ALU(input logic [3:0] op, input logic [4:0] rd,
      input logic [4:0] ra, input logic [4:0] rb);
    return enc(1'b0, 1'b0, 1'b1, 2'd2, op, ra, rb, rd, 8'd0);
  endfunction
  function automatic logic [31:0] OUTR(input logic [4:0] ra);
    return enc(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, ra, 5'd0, 5'd0, 8'd0);
  endfunction
  function automatic logic [31:0] IN(input logic [4:0] rd);
    return enc(1'b0, 1'b0, 1'b1, 2'd1, 4'd0, 5'd0, 5'd0, rd, 8'd0);
  endfunction
  function automatic logic [31:0] BNE(input logic [4:0] ra, input logic [4:0] rb,
      input logic [7:0] imm);
    return enc(1'b0, 1'b1, 1'b0, 2'd2, 4'hB, ra, rb, 5'd0, imm);
  endfunction
  function automatic logic [31:0] JMP(input logic [7:0] imm);
    return enc(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 5'd0, 5'd0, 5'd0, imm);
  endfunction

  // Reference model: architectural state advanced one whole instruction at a time;
  // m_cyc only tracks how many clocks of the current instruction have elapsed.
  logic [7:0]  m_pc, m_addr;
  logic [31:0] m_regs [32];
  logic [31:0] m_hex, m_sw, m_ins, e_a, e_b, e_res, e_se;
  logic        m_hv, m_ready, m_halted, e_flag;
  int          m_cyc;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = '0; m_addr = '0; m_hex = '0; m_sw = '0;
      m_hv = 1'b0; m_ready = 1'b0; m_halted = 1'b0; m_cyc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      m_hv = 1'b0;
      if (!m_halted) begin
        m_ins = mem[m_pc];
        m_cyc++;
        if (m_cyc == 1) m_addr = m_pc;
        if (m_cyc == 3 && m_ins[29] && m_ins[28:27] == 2'b01) begin
          m_ready = 1'b1;
        end else if (m_ready) begin
          if (sw_valid) begin
            m_sw = SW;
            m_ready = 1'b0;
          end
        end else if (m_cyc >= 4) begin
          e_a = (m_ins[22:18] == 5'd0) ? 32'd0 : m_regs[m_ins[22:18]];
          e_b = (m_ins[17:13] == 5'd0) ? 32'd0 : m_regs[m_ins[17:13]];
          e_se = {{24{m_ins[7]}}, m_ins[7:0]};
          e_res = '0;
          e_flag = 1'b0;
          case (m_ins[26:23])
            4'd0: e_res = e_a + e_b;
            4'd1: e_res = e_a - e_b;
            4'd2: e_res = e_a & e_b;
            4'd3: e_res = e_a | e_b;
            4'd4: e_res = e_a ^ e_b;
            4'd5: e_res = e_a << e_b[4:0];
            4'd6: e_res = e_a >> e_b[4:0];
            4'd7: e_res = $signed(e_a) >>> e_b[4:0];
            4'd8: e_flag = $signed(e_a) < $signed(e_b);
            4'd9: e_flag = e_a < e_b;
            4'd10: e_flag = e_a == e_b;
            4'd11: e_flag = e_a != e_b;
            4'd12: e_flag = $signed(e_a) >= $signed(e_b);
            4'd13: e_flag = e_a >= e_b;
            default: ;
          endcase
          if (m_ins[26:23] >= 4'd8 && m_ins[26:23] <= 4'd13) e_res = {31'd0, e_flag};
          if (m_ins[29] && m_ins[28:27] != 2'b11 && m_ins[12:8] != 5'd0)
            m_regs[m_ins[12:8]] = (m_ins[28:27] == 2'b00) ? e_se :
                                  (m_ins[28:27] == 2'b01) ? m_sw : e_res;
          if (m_ins[28:27] == 2'b11) begin
            m_hex = e_a;
            m_hv = 1'b1;
          end
          if (m_ins[31] && m_ins[7:0] == 8'd0) m_halted = 1'b1;
          m_pc = m_pc + ((m_ins[31] || (m_ins[30] && e_flag)) ? m_ins[7:0] : 8'd1);
          m_cyc = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", 32'(imem_addr), 32'(m_addr));
      check("sw_ready", 32'(sw_ready), 32'(m_ready));
      check("HEX", HEX, m_hex);
      check("hex_valid", 32'(hex_valid), 32'(m_hv));
      check("halted", 32'(halted), 32'(m_halted));
    end
  end

  logic [31:0] q_hex [$];
  logic [15:0] q16 [$];
  int n_at2 = 0, n_hs = 0, n_rdy = 0, seen254 = 0;
  logic [7:0] prev_addr = '0;

  always @(negedge clk) begin
    if (hex_valid) q_hex.push_back(HEX);
    if (hex_valid16) q16.push_back(HEX16);
    if (sw_ready) n_rdy++;
    if (imem_addr == 8'd2 && prev_addr != 8'd2) n_at2++;
    if (imem_addr == 8'd254) seen254 = 1;
    prev_addr = imem_addr;
  end
  always @(posedge clk) if (!reset && sw_valid && sw_ready) n_hs++;

  task automatic clear_mon();
    q_hex.delete();
    n_at2 = 0; n_hs = 0; n_rdy = 0; seen254 = 0;
  endtask

  task automatic load_halts();
    for (int i = 0; i < 256; i++) mem[i] = JMP(8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    clear_mon();
    reset = 1'b0;
  endtask

  task automatic run_until_halt(input string name, input int maxc);
    int n;
    n = 0;
    while (!halted && n < maxc) begin
      tick();
      n++;
    end
    check({name, "_halt_reached"}, 32'(halted), 32'd1);
  endtask

  task automatic wait_ready(input string name, input int exp_n);
    int n;
    n = 0;
    while (!sw_ready && n < 60) begin
      tick();
      n++;
    end
    check({name, "_ready_latency"}, n, exp_n);
  endtask

  task automatic check_q(input string name, input int cnt, input logic [31:0] e0,
      input logic [31:0] e1);
    check({name, "_pulses"}, q_hex.size(), cnt);
    if (q_hex.size() > 0 && cnt > 0) check({name, "_hex0"}, q_hex[0], e0);
    if (q_hex.size() > 1 && cnt > 1) check({name, "_hex1"}, q_hex[1], e1);
  endtask

  initial begin
    int n, rc;
    logic [7:0] frozen;
    reset = 1'b1; reset16 = 1'b1;
    sw_valid = 1'b0; SW = '0; sw_valid16 = 1'b0; SW16 = '0;
    load_halts();
    for (int i = 0; i < 16; i++) mem16[i] = JMP(8'd0);

    // Immediate load, sign extension, ADD, OUT
    mem[0] = LI(5'd1, 8'h05);
    mem[1] = LI(5'd2, 8'hFE);
    mem[2] = ALU(4'h0, 5'd3, 5'd1, 5'd2);
    mem[3] = OUTR(5'd3);
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_hex", HEX, 32'd0);
    check("rst_hv", 32'(hex_valid), 32'd0);
    check("rst_ready", 32'(sw_ready), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    clear_mon();
    reset = 1'b0;
    n = 0;
    while (!hex_valid && n < 100) begin
      tick();
      n++;
    end
    check("t1_out_latency", n, 32'd16);
    check("t1_hex", HEX, 32'h0000_0003);
    run_until_halt("t1", 40);
    check_q("t1", 1, 32'h3, 32'h0);
    frozen = imem_addr;
    repeat (5) tick();
    check("t1_addr_frozen", 32'(imem_addr), 32'(frozen));
    check("t1_addr_at_halt", 32'(frozen), 32'd4);

    // Switch input with delayed valid
    load_halts();
    mem[0] = IN(5'd4);
    mem[1] = OUTR(5'd4);
    do_reset();
    wait_ready("t2", 3);
    rc = 1;
    repeat (3) begin
      tick();
      if (sw_ready) rc++;
    end
    SW = 32'h0000_1234;
    sw_valid = 1'b1;
    tick();
    check("t2_ready_drop", 32'(sw_ready), 32'd0);
    check("t2_ready_cycles", rc, 32'd4);
    check("t2_ready_mon", n_rdy, 32'd4);
    SW = 32'h0000_5678;
    n = 0;
    while (!hex_valid && n < 20) begin
      tick();
      n++;
    end
    check("t2_hex", HEX, 32'h0000_1234);
    sw_valid = 1'b0;
    run_until_halt("t2", 20);
    check_q("t2", 1, 32'h1234, 32'h0);
    check("t2_transfers", n_hs, 32'd1);

    // Countdown loop with wrap-around jumps
    load_halts();
    mem[0]   = JMP(8'hFE);
    mem[254] = LI(5'd1, 8'h03);
    mem[255] = JMP(8'h02);
    mem[1]   = LI(5'd5, 8'h01);
    mem[2]   = ALU(4'h1, 5'd1, 5'd1, 5'd5);
    mem[3]   = BNE(5'd1, 5'd0, 8'hFF);
    mem[4]   = OUTR(5'd1);
    do_reset();
    run_until_halt("t3", 120);
    check("t3_loop_iters", n_at2, 32'd3);
    check("t3_wrap_fetch", seen254, 32'd1);
    check_q("t3", 1, 32'h0, 32'h0);

    // r0 stays zero; halt freezes fetch
    load_halts();
    mem[0] = LI(5'd1, 8'h11);
    mem[1] = OUTR(5'd1);
    mem[2] = LI(5'd0, 8'h7F);
    mem[3] = OUTR(5'd0);
    do_reset();
    run_until_halt("t4", 60);
    check_q("t4", 2, 32'h11, 32'h0);
    repeat (5) tick();
    check("t4_addr_frozen", 32'(imem_addr), 32'd4);
    check("t4_halted_stays", 32'(halted), 32'd1);

    // Reset during WAIT_IN and during HALT
    load_halts();
    mem[0] = LI(5'd1, 8'h33);
    mem[1] = OUTR(5'd1);
    mem[2] = IN(5'd4);
    mem[3] = OUTR(5'd4);
    do_reset();
    wait_ready("t5a", 11);
    reset = 1'b1;
    sw_valid = 1'b1;
    SW = 32'h0000_BEEF;
    tick();
    check("t5a_ready", 32'(sw_ready), 32'd0);
    check("t5a_hex", HEX, 32'd0);
    check("t5a_addr", 32'(imem_addr), 32'd0);
    check("t5a_halted", 32'(halted), 32'd0);
    check("t5a_transfers", n_hs, 32'd0);
    sw_valid = 1'b0;
    clear_mon();
    reset = 1'b0;
    wait_ready("t5b", 11);
    SW = 32'h0000_0077;
    sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    run_until_halt("t5b", 30);
    check_q("t5b", 2, 32'h33, 32'h77);
    reset = 1'b1;
    tick();
    check("t5c_halted", 32'(halted), 32'd0);
    check("t5c_hex", HEX, 32'd0);
    check("t5c_addr", 32'(imem_addr), 32'd0);
    clear_mon();
    SW = 32'h0000_0099;
    sw_valid = 1'b1;
    reset = 1'b0;
    run_until_halt("t5c", 40);
    sw_valid = 1'b0;
    check("t5c_ready_cycles", n_rdy, 32'd1);
    check_q("t5c", 2, 32'h33, 32'h99);

    // 16-bit build: SRA, out-of-range register, PC wrap mod 16
    mem16[0]  = LI(5'd1, 8'h01);
    mem16[1]  = LI(5'd2, 8'h0F);
    mem16[2]  = ALU(4'h5, 5'd3, 5'd1, 5'd2);
    mem16[3]  = ALU(4'h7, 5'd4, 5'd3, 5'd2);
    mem16[4]  = OUTR(5'd4);
    mem16[5]  = LI(5'd9, 8'h55);
    mem16[6]  = OUTR(5'd9);
    mem16[7]  = JMP(8'h17);
    mem16[14] = OUTR(5'd3);
    mem16[15] = JMP(8'h0A);
    q16.delete();
    reset16 = 1'b0;
    n = 0;
    while (!halted16 && n < 200) begin
      tick();
      n++;
    end
    check("t6_halt_reached", 32'(halted16), 32'd1);
    check("t6_pulses", q16.size(), 32'd3);
    if (q16.size() > 0) check("t6_sra", 32'(q16[0]), 32'h0000_FFFF);
    if (q16.size() > 1) check("t6_r9", 32'(q16[1]), 32'h0);
    if (q16.size() > 2) check("t6_sll", 32'(q16[2]), 32'h0000_8000);
    repeat (3) tick();
    check("t6_addr_wrap", 32'(imem_addr16), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
